// File: rtl/irq_ctrl.sv
// Machine-mode interrupt/trap sequencer: WFI sleep, interrupt entry and MRET return.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on ext_irq/timer_irq.
module irq_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
  parameter int          IRQ_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        valid_ID,
  input  logic        isWFI_ID,
  input  logic        isMRET_ID,
  input  logic [31:0] pc_ID,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        stall_wfi,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {RUN = 2'd0, SLEEP = 2'd1, TRAP = 2'd2, RET = 2'd3} state_t;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  logic [IRQ_W-1:0] irq_raw;
  logic [IRQ_W-1:0] irq_s;

  assign irq_raw = {ext_irq, timer_irq};

`ifdef IRQ_SYNC_EN
  logic [IRQ_W-1:0] sync1_q, sync1_d;
  logic [IRQ_W-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {IRQ_W{1'b0}};
      sync2_q <= {IRQ_W{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_raw;
`endif

  state_t      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [1:0]  mie_q, mie_d;           // [1] MEIE, [0] MTIE
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] wfi_pc_q, wfi_pc_d;
  logic        stall_wfi_q, stall_wfi_d;
  logic        flush_q, flush_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        pend_s;
  logic [31:0] cause_s;
  logic        take_trap_s;
  logic [31:0] trap_epc_s;

  assign pend_s  = |(irq_s & mie_q);
  assign cause_s = (irq_s[1] && mie_q[1]) ? CAUSE_EXT : CAUSE_TIMER;

  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    wfi_pc_d       = wfi_pc_q;
    stall_wfi_d    = 1'b0;
    flush_d        = 1'b0;
    redirect_d     = 1'b0;
    redirect_pc_d  = 32'h0;
    take_trap_s    = 1'b0;
    trap_epc_s     = 32'h0;

    if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        12'h304: mie_d    = {csr_wdata[11], csr_wdata[7]};
        12'h305: mtvec_d  = csr_wdata & ALIGN_MASK;
        12'h341: mepc_d   = csr_wdata & ALIGN_MASK;
        12'h342: mcause_d = csr_wdata;
        default: ;
      endcase
    end

    // FSM updates come after software writes so they take precedence
    case (state_q)
      RUN: begin
        if (valid_ID) begin
          if (isMRET_ID) begin
            state_d        = RET;
            flush_d        = 1'b1;
            redirect_d     = 1'b1;
            redirect_pc_d  = mepc_q;
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
          end else if (pend_s && mstatus_mie_q) begin
            take_trap_s = 1'b1;
            trap_epc_s  = pc_ID & ALIGN_MASK;
          end else if (isWFI_ID) begin
            state_d     = SLEEP;
            stall_wfi_d = 1'b1;
            wfi_pc_d    = (pc_ID + 32'd4) & ALIGN_MASK;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      SLEEP: begin
        if (pend_s) begin
          if (mstatus_mie_q) begin
            take_trap_s = 1'b1;
            trap_epc_s  = wfi_pc_q;
          end else begin
            state_d = RUN;
          end
        end else begin
          stall_wfi_d = 1'b1;
        end
      end
      TRAP:    state_d = RUN;
      RET:     state_d = RUN;
      default: state_d = RUN;
    endcase

    if (take_trap_s) begin
      state_d        = TRAP;
      flush_d        = 1'b1;
      redirect_d     = 1'b1;
      redirect_pc_d  = mtvec_q;
      mepc_d         = trap_epc_s;
      mcause_d       = cause_s;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else begin
      trap_epc_s = trap_epc_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 2'b00;
      mtvec_q        <= MTVEC_RST & ALIGN_MASK;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      wfi_pc_q       <= 32'h0;
      stall_wfi_q    <= 1'b0;
      flush_q        <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= 32'h0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      wfi_pc_q       <= wfi_pc_d;
      stall_wfi_q    <= stall_wfi_d;
      flush_q        <= flush_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = {19'h0, 2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      12'h304: csr_rdata = {20'h0, mie_q[1], 3'b000, mie_q[0], 7'h0};
      12'h344: csr_rdata = {20'h0, irq_s[1], 3'b000, irq_s[0], 7'h0};
      12'h305: csr_rdata = mtvec_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      default: csr_rdata = 32'h0;
    endcase
  end

  assign stall_wfi   = stall_wfi_q;
  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule
